dxdt_sequencer: RTL
===================

Name: dxdt_sequencer

Overview:
- Controller that sequences one DXDT (Y = D·X·Dᵀ, 8x8) engine over repeated frames.
- Loads 64 X elements from a valid/ready input stream into the engine's X register file while holding the engine's reset high.
- Releases the engine's reset to start the compute, waits for done, then streams out the 64 Y results in row-major order.
- Sits between the upstream sample source and the DXDT datapath; the engine is reused frame after frame without testbench-style manual sequencing.

Parameters:
N, 8, input element width; Y width is N+12
NUM_ELEMS, 64, elements per frame (8x8, row-major: index = 8*row+col)
TIMEOUT, 1023, max RUN cycles before the watchdog aborts the frame

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  upstream element valid
in_data  in  N  upstream X element
in_ready  out  1  element accepted when in_valid&in_ready
x_wr_en  out  1  write strobe to X register file
x_wr_addr  out  6  X index 0..63
x_wr_data  out  N  X element
dxdt_reset  out  1  drives DXDT reset (high = hold/load, low = compute)
dxdt_done  in  1  DXDT completion
y_sel  out  6  Y index into DXDT output mux
y_data  in  N+12  selected Y element
out_valid  out  1  result valid
out_data  out  N+12  result element
out_last  out  1  high with element 63
out_ready  in  1  downstream accept
busy  out  1  high in RUN or UNLOAD
timeout_err  out  1  sticky watchdog flag
frame_count  out  8  completed frames, wraps 255->0

Behaviour:
- Reset (sync): state=LOAD, cnt=0, wdog=0, dxdt_reset=1, timeout_err=0, frame_count=0.
  - Outputs x_wr_en, out_valid, out_last and busy are 0 during the reset cycle.
  - Reset mid-frame discards all progress; no partial output.
- States: LOAD, RUN, UNLOAD.
- LOAD:
  - in_ready=1, dxdt_reset=1, busy=0.
  - On in_valid&in_ready: x_wr_en=1, x_wr_addr=cnt, x_wr_data=in_data (combinational, same cycle); cnt++.
  - Accepting element 63: cnt←0, wdog←0, next state RUN.
  - in_valid low stalls; cnt holds.
- RUN:
  - dxdt_reset=0, in_ready=0, busy=1; wdog increments each cycle.
  - dxdt_done is ignored on the first RUN cycle (wdog==0), which masks a stale done.
  - dxdt_done=1 with wdog≥1 → UNLOAD.
  - wdog==TIMEOUT without done → timeout_err←1, state←LOAD, dxdt_reset=1 next cycle, no output.
  - If done and timeout occur in the same cycle, done wins.
- UNLOAD:
  - dxdt_reset=0 so Y stays stable; busy=1.
  - y_sel=cnt; out_valid=1; out_data=y_data (combinational pass-through); out_last=(cnt==63).
  - On out_valid&out_ready: cnt++.
  - Accepting element 63: cnt←0, frame_count++, state←LOAD.
  - out_ready low holds out_data and y_sel stable.
- timeout_err is cleared only by reset.
- Minimum frame latency: 64 load cycles + compute + 64 unload cycles.
- LOAD always follows UNLOAD. The next frame's first element is accepted in the cycle after the last output handshake.

Decomposition:
- Package dxdt_pkg:
  - state enum {LOAD, RUN, UNLOAD}
  - localparams IDX_W=6, Y_W=N+12, NUM_ELEMS=64, DEFAULT_TIMEOUT=1023
- One natural sub-module: dxdt_watchdog.
  - Inputs: clear, enable.
  - Outputs: first_cycle, expired.
  - Parameter: TIMEOUT.
- The counters and the FSM stay in dxdt_sequencer.

Test Plan:
- Nominal frame: X[i]=i%8 streamed back-to-back, DXDT model asserts done 20 cycles after dxdt_reset falls → x_wr_addr 0..63 in order, RUN lasts 21 cycles, 64 outputs, y_sel 0..63 matches out_data, out_last only on element 63, frame_count=1.
- Backpressure: in_valid toggled 1/0 during LOAD, out_ready low for 3 cycles at element 10 → no lost or duplicated writes; out_data and y_sel stable while stalled; final frame_count=1.
- Timeout: TIMEOUT=15, done never asserted → timeout_err=1 on the 16th RUN cycle, state returns to LOAD, dxdt_reset=1, no out_valid, frame_count stays 0.
- Stale done: dxdt_done held high when RUN is entered, then low, then a real pulse 5 cycles later → first-cycle done ignored; UNLOAD begins after the real pulse.
- Reset mid-operation: reset asserted at output element 30 → next cycle state=LOAD, cnt=0, out_valid=0, dxdt_reset=1, frame_count=0. A following full frame completes normally with frame_count=1.
- Wrap: 256 consecutive frames → frame_count returns to 0; timeout_err stays 0.

Source files
------------

// File: rtl/dxdt_pkg.sv
// Shared constants for the DXDT frame sequencer: index/result widths, frame size and FSM encodings.
package dxdt_pkg;

  localparam int unsigned DEFAULT_N       = 8;
  localparam int unsigned IDX_W           = 6;
  localparam int unsigned Y_W             = DEFAULT_N + 12;
  localparam int unsigned NUM_ELEMS       = 64;
  localparam int unsigned DEFAULT_TIMEOUT = 1023;

  typedef logic [1:0] state_t;

  localparam state_t LOAD   = 2'd0;
  localparam state_t RUN    = 2'd1;
  localparam state_t UNLOAD = 2'd2;

  function automatic logic is_last(input logic [IDX_W-1:0] idx);
    return idx == IDX_W'(NUM_ELEMS - 1);
  endfunction

endpackage

// File: rtl/dxdt_watchdog.sv
// Counts RUN cycles; flags the first cycle (to mask a stale done) and expiry at TIMEOUT.
module dxdt_watchdog
  import dxdt_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic first_cycle,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [W-1:0] wdog_q, wdog_d;

  assign first_cycle = (wdog_q == '0);
  assign expired     = (wdog_q == W'(TIMEOUT));

  // Saturates at TIMEOUT so the count can never wrap back to a "first cycle".
  always_comb begin
    wdog_d = wdog_q;
    if (clear) begin
      wdog_d = '0;
    end else if (enable && !expired) begin
      wdog_d = wdog_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    wdog_q <= wdog_d;
  end

endmodule

// File: rtl/dxdt_sequencer.sv
// Frame sequencer for one DXDT engine: load 64 X elements, run the engine, stream out 64 Y results.
module dxdt_sequencer
  import dxdt_pkg::*;
#(
  parameter int unsigned N       = DEFAULT_N,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  output logic             in_ready,
  output logic             x_wr_en,
  output logic [IDX_W-1:0] x_wr_addr,
  output logic [N-1:0]     x_wr_data,
  output logic             dxdt_reset,
  input  logic             dxdt_done,
  output logic [IDX_W-1:0] y_sel,
  input  logic [N+11:0]    y_data,
  output logic             out_valid,
  output logic [N+11:0]    out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             timeout_err,
  output logic [7:0]       frame_count
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [7:0]       frame_q, frame_d;
  logic             terr_q, terr_d;
  logic             in_load, in_run, in_unload;
  logic             wd_first, wd_expired;

  // Any unused state encoding behaves as LOAD and is normalised on the next edge.
  assign in_run    = (state_q == RUN);
  assign in_unload = (state_q == UNLOAD);
  assign in_load   = !in_run && !in_unload;

  dxdt_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk        (clk),
    .clear      (reset | !in_run),
    .enable     (in_run),
    .first_cycle(wd_first),
    .expired    (wd_expired)
  );

  assign in_ready    = in_load & ~reset;
  assign x_wr_en     = in_ready & in_valid;
  assign x_wr_addr   = cnt_q;
  assign x_wr_data   = in_data;
  assign dxdt_reset  = reset | in_load;
  assign y_sel       = cnt_q;
  assign out_valid   = in_unload & ~reset;
  assign out_data    = y_data;
  assign out_last    = out_valid & is_last(cnt_q);
  assign busy        = (in_run | in_unload) & ~reset;
  assign timeout_err = terr_q;
  assign frame_count = frame_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    terr_d  = terr_q;
    if (in_run) begin
      // Done beats the watchdog when both land in the same cycle.
      if (dxdt_done && !wd_first) begin
        state_d = UNLOAD;
      end else if (wd_expired) begin
        terr_d  = 1'b1;
        state_d = LOAD;
      end
    end else if (in_unload) begin
      if (out_ready) begin
        if (is_last(cnt_q)) begin
          cnt_d   = '0;
          frame_d = frame_q + 8'd1;
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
    end else begin
      state_d = LOAD;
      if (x_wr_en) begin
        if (is_last(cnt_q)) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      frame_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      terr_q  <= terr_d;
    end
  end

endmodule
